// File: rtl/br_lite_inject_arbiter.sv
// br_pkg: broadcast flit format shared by the injection arbiter and its neighbours.
package br_pkg;
    localparam int unsigned BR_ADDR_W    = 16;
    localparam int unsigned BR_ID_W      = 8;
    localparam int unsigned BR_PAYLOAD_W = 32;

    typedef enum logic [1:0] {
        BR_SVC_ALL   = 2'd0,
        BR_SVC_TGT   = 2'd1,
        BR_SVC_CLEAR = 2'd2,
        BR_SVC_RSVD  = 2'd3
    } br_svc_e;

    typedef struct packed {
        br_svc_e                 service;
        logic [BR_ADDR_W-1:0]    source;
        logic [BR_ADDR_W-1:0]    target;
        logic [BR_ID_W-1:0]      id;
        logic [BR_PAYLOAD_W-1:0] payload;
    } br_data_t;
endpackage

// br_lite_inject_arbiter: round-robin arbiter injecting local broadcast flits
// into a router local input port over 4-phase handshakes.
//   clk_i, rst_i       clock, asynchronous active-high reset
//   src_flit_i         per-requester flit
//   src_req_i/ack_o    per-requester 4-phase handshake
//   local_busy_i       router busy; gates only the start of a new injection
//   flit_o/req_o/ack_i 4-phase handshake toward the router local input
//   inj_cnt_o          injected flits, wraps
//   rej_cnt_o          rejected flits (non-broadcast services), saturates
module br_lite_inject_arbiter
    import br_pkg::*;
#(
    parameter logic [15:0] ADDRESS = 16'h0000,
    parameter int unsigned NSRC    = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  br_data_t [NSRC-1:0]   src_flit_i,
    input  logic     [NSRC-1:0]   src_req_i,
    output logic     [NSRC-1:0]   src_ack_o,
    input  logic                  local_busy_i,
    output br_data_t              flit_o,
    output logic                  req_o,
    input  logic                  ack_i,
    output logic     [15:0]       inj_cnt_o,
    output logic     [7:0]        rej_cnt_o
);

    localparam int unsigned IW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        SEND    = 3'd2,
        DROP    = 3'd3,
        SRC_ACK = 3'd4
    } state_t;

    state_t              state_q, state_n;
    logic [IW-1:0]       grant_q, grant_n;
    br_data_t            flit_q, flit_n;
    logic [BR_ID_W-1:0]  id_q, id_n;
    logic [15:0]         inj_q, inj_n;
    logic [7:0]          rej_q, rej_n;
    logic                req_q, req_n;
    logic [NSRC-1:0]     sack_q, sack_n;

    logic                rr_found;
    logic [IW-1:0]       rr_idx;

    // Round-robin search starting just above the last grant, wrapping around.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = grant_q;
        for (int unsigned i = 1; i <= NSRC; i++) begin
            if (!rr_found && src_req_i[IW'((32'(grant_q) + i) % NSRC)]) begin
                rr_found = 1'b1;
                rr_idx   = IW'((32'(grant_q) + i) % NSRC);
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        flit_n  = flit_q;
        id_n    = id_q;
        inj_n   = inj_q;
        rej_n   = rej_q;

        case (state_q)
            IDLE: begin
                if ((|src_req_i) && !local_busy_i) begin
                    state_n = ARB;
                end
            end
            ARB: begin
                if (rr_found) begin
                    grant_n        = rr_idx;
                    flit_n         = src_flit_i[rr_idx];
                    flit_n.source  = ADDRESS;
                    flit_n.id      = id_q;
                    if ((flit_n.service == BR_SVC_ALL) || (flit_n.service == BR_SVC_TGT)) begin
                        state_n = SEND;
                    end else begin
                        state_n = SRC_ACK;
                        if (rej_q != 8'hFF) begin
                            rej_n = rej_q + 8'd1;
                        end
                    end
                end else begin
                    // Requester withdrew between IDLE and ARB; nothing to serve.
                    state_n = IDLE;
                end
            end
            SEND: begin
                if (ack_i) begin
                    state_n = DROP;
                end
            end
            DROP: begin
                if (!ack_i) begin
                    state_n = SRC_ACK;
                    id_n    = id_q + BR_ID_W'(1);
                    inj_n   = inj_q + 16'd1;
                end
            end
            SRC_ACK: begin
                if (!src_req_i[grant_q]) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        req_n  = (state_n == SEND);
        sack_n = (state_n == SRC_ACK) ? (NSRC'(1) << grant_n) : '0;
    end

    // State and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= IW'(NSRC - 1);
            flit_q  <= '0;
            id_q    <= '0;
            inj_q   <= '0;
            rej_q   <= '0;
            req_q   <= 1'b0;
            sack_q  <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            flit_q  <= flit_n;
            id_q    <= id_n;
            inj_q   <= inj_n;
            rej_q   <= rej_n;
            req_q   <= req_n;
            sack_q  <= sack_n;
        end
    end

    assign flit_o    = flit_q;
    assign req_o     = req_q;
    assign src_ack_o = sack_q;
    assign inj_cnt_o = inj_q;
    assign rej_cnt_o = rej_q;

endmodule

// File: doc/br_lite_inject_arbiter.md
BR_LITE_INJECT_ARBITER -- requirements
Module: br_lite_inject_arbiter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter: ADDRESS, default 0, 16-bit router address written into the source field of every injected flit.
REQ-003 Parameter: NSRC, default 4 (range 2..8), number of local requesters.
REQ-004 Port: clk_i, input, 1, clock; all state changes on its rising edge.
REQ-005 Port: rst_i, input, 1, asynchronous active-high reset.
REQ-006 Port: src_flit_i, input, NSRC x br_data_t, per-requester broadcast flit.
REQ-007 Port: src_req_i, input, NSRC, per-requester request; 4-phase.
REQ-008 Port: src_ack_o, output, NSRC, per-requester acknowledge; 4-phase.
REQ-009 Port: local_busy_i, input, 1, router local-busy flag; no new injection may start while high.
REQ-010 Port: flit_o, output, br_data_t, flit to router local input.
REQ-011 Port: req_o, output, 1, request to router local input.
REQ-012 Port: ack_i, input, 1, acknowledge from router local input.
REQ-013 Port: inj_cnt_o, output, 16, injected-flit count; wraps modulo 2^16.
REQ-014 Port: rej_cnt_o, output, 8, rejected-flit count; saturates at 255.

Function
REQ-015 FSM states: IDLE, ARB, SEND, DROP, SRC_ACK.
REQ-016 IDLE -> ARB when src_req_i != 0 and local_busy_i == 0, else stay; no other state samples local_busy_i.
REQ-017 ARB: round-robin grant; the first requesting index above the last grant, wrapping to the lowest; the last grant is NSRC-1 after reset, so index 0 wins first.
REQ-018 ARB: the granted flit is latched into flit_o, source := ADDRESS, id := id counter, all other fields copied unchanged.
REQ-019 ARB: service BR_SVC_ALL or BR_SVC_TGT -> SEND; any other service (incl. BR_SVC_CLEAR) -> SRC_ACK as a reject, with rej_cnt_o incremented (saturating) and no router transaction.
REQ-020 SEND: req_o = 1; flit_o stable; on ack_i = 1 -> DROP.
REQ-021 DROP: req_o = 0; on ack_i = 0 -> SRC_ACK, with the id counter and inj_cnt_o each incremented by 1.
REQ-022 The id counter SHALL be the width of the br_data_t id field and wrap modulo 2^width.
REQ-023 SRC_ACK: src_ack_o[grant] = 1, all other src_ack_o bits 0; on src_req_i[grant] = 0 -> IDLE.
REQ-024 Latency: ARB follows the IDLE request cycle by 1 cycle; req_o rises 2 cycles after the first cycle with src_req_i high, given local_busy_i low and an idle FSM.
REQ-025 req_o SHALL be 1 only in SEND; at most one src_ack_o bit SHALL be high, and only in SRC_ACK.
REQ-026 A requester dropping src_req_i before SRC_ACK violates protocol; the block SHALL still complete the router transaction, then leave SRC_ACK on the first cycle in that state.
REQ-027 local_busy_i rising during SEND/DROP SHALL NOT abort the transaction.
REQ-028 Simultaneous requests SHALL be served one at a time; no requester is starved while others toggle.

Reset
REQ-029 rst_i high SHALL force IDLE, req_o = 0, src_ack_o = 0, flit_o = 0, id counter = 0, inj_cnt_o = 0, rej_cnt_o = 0, last grant = NSRC-1, regardless of the current state.
REQ-030 A reset during SEND SHALL drop req_o immediately (asynchronously); after release the block SHALL restart in IDLE without replaying the flit.

Verification
REQ-031 Single source 0, service ALL, ADDRESS=16'h0102 -> req_o rises 2 cycles later, flit_o.source=16'h0102, id=0; after the ack_i pulse, src_ack_o[0]=1 and inj_cnt_o=1.
REQ-032 Sources 0..3 requesting continuously, four transactions -> grant order 0,1,2,3; ids 0,1,2,3; inj_cnt_o=4.
REQ-033 Source 2, service CLEAR -> req_o never rises, src_ack_o[2]=1, rej_cnt_o=1; 300 rejects -> rej_cnt_o=255.
REQ-034 local_busy_i high with source 1 requesting -> the FSM stays in IDLE; local_busy_i low -> req_o rises 2 cycles later.
REQ-035 rst_i pulsed while req_o=1 -> req_o=0 in the same cycle, all counters 0; the next grant goes to index 0.
REQ-036 Id wrap: after 2^idwidth injections -> the next flit has id=0 and inj_cnt_o continues counting.
